ecp5pll_phase_ctrl: RTL and testbench
=====================================

# ecp5pll_phase_ctrl

Sequencer for the dynamic-phase and reset controls of the `ecp5pll` wrapper (instantiated with `dynamic_en=1`, `reset_en=1`). Accepts phase-shift requests ("move output N by K fine steps up/down"), converts them into correctly timed `phasesel`/`phasedir`/`phasestep` waveforms, and tracks the accumulated phase position of each output. Also owns PLL reset and lock supervision: it pulses PLL reset, waits for lock with timeout and retry, and aborts stepping on loss of lock. Sits between user/config logic and the PLL, in the PLL input clock domain.

## Interface
- `SEL_SETUP`, 2: cycles `phasesel`/`phasedir` are held stable before the first `phasestep` rise.
- `STEP_HOLD`, 4: cycles `phasestep` is high per step; minimum 1.
- `STEP_GAP`, 4: cycles `phasestep` is low after each step; minimum 1.
- `RST_CYCLES`, 16: cycles `pll_reset` is held high per reset pulse.
- `LOCK_TIMEOUT`, 65535: cycles allowed in `WAIT_LOCK` before a retry.
- `clk_i  in  1`: controller clock (PLL reference clock).
- `reset  in  1`: synchronous, active-high.
- `req_valid  in  1`: phase request valid.
- `req_ready  out  1`: high only in `IDLE` while the synchronized lock is high.
- `req_sel  in  2`: output select, same numbering as the wrapper: 0=CLKOP, 1=CLKOS, 2=CLKOS2, 3=CLKOS3.
- `req_dir  in  1`: 1 = advance (+1 per step), 0 = retard (-1 per step).
- `req_steps  in  8`: number of fine steps, 0..255.
- `relock_req  in  1`: single-cycle pulse that forces a PLL reset sequence; accepted only in `IDLE`.
- `err_clr  in  1`: clears the sticky error flags.
- `locked  in  1`: PLL LOCK, asynchronous.
- `pll_reset  out  1`: to the wrapper's `reset`.
- `phasesel  out  2`, `phasedir  out  1`, `phasestep  out  1`: to the wrapper.
- `phaseloadreg  out  1`: constant 0.
- `done  out  1`: one-cycle pulse when a request completes or is aborted.
- `busy  out  1`: high in every state except `IDLE`.
- `err_lock  out  1`: sticky; set when lock is lost during `SETUP`, `STEP_HI` or `STEP_LO`.
- `err_timeout  out  1`: sticky; set on each `LOCK_TIMEOUT` expiry.
- `pos_o  out  64`: four 16-bit signed position counters. `pos_o[16*n+:16]` holds output n.

## Operation
- `locked` passes through a 2-flop synchronizer to give `lock_s`. All decisions use `lock_s`.
- All outputs are registered.
- States:
  - `RST_PLL`: `pll_reset`=1 for `RST_CYCLES` cycles, then go to `WAIT_LOCK`.
  - `WAIT_LOCK`: when `lock_s`=1, go to `IDLE`. After `LOCK_TIMEOUT` cycles without lock, set `err_timeout` and go to `RST_PLL` (retries indefinitely).
  - `IDLE`:
    - `relock_req` has priority over `req_valid` in the same cycle. It clears all `pos` counters and goes to `RST_PLL`. The request is not accepted.
    - On a handshake: latch sel/dir/steps and drive `phasesel`/`phasedir`.
    - If steps=0, pulse `done` in the next cycle and stay in `IDLE`. Otherwise go to `SETUP`.
  - `SETUP`: hold for `SEL_SETUP` cycles, then go to `STEP_HI`.
  - `STEP_HI`: `phasestep`=1 for `STEP_HOLD` cycles. On the first cycle, update `pos[sel]` by ±1 (modulo 2^16) and decrement the remaining-step counter. Then go to `STEP_LO`.
  - `STEP_LO`: `phasestep`=0 for `STEP_GAP` cycles. Then go to `STEP_HI` if steps remain. Otherwise pulse `done` and go to `IDLE`.
- Loss of lock (`lock_s`=0) in `SETUP`, `STEP_HI` or `STEP_LO`:
  - Next cycle: `phasestep`=0, `err_lock`=1, `done` pulse.
  - Go to `WAIT_LOCK`.
  - `pos` keeps the steps already issued.
- Loss of lock while in `IDLE`: go to `WAIT_LOCK`. No error is flagged.
- `phasesel`/`phasedir` change only on request acceptance. They hold their value through `IDLE` afterwards.
- `err_clr` clears both sticky flags. If a set event occurs in the same cycle, set wins.
- `reset` (may arrive at any time, including mid-step) produces these values on the next edge:
  - state = `RST_PLL`
  - `pll_reset`=1
  - `phasestep`=0, `phasesel`=0, `phasedir`=0, `phaseloadreg`=0
  - `done`=0, `req_ready`=0, `busy`=1
  - `err_*`=0, `pos_o`=0
  - synchronizer flops cleared

## Timing
- Handshake cycle = 0. Then:
  - `SETUP` occupies cycles 1..`SEL_SETUP`.
  - `phasestep` for step k (k=0..N-1) is high in cycles `SEL_SETUP`+1+k·(`STEP_HOLD`+`STEP_GAP`) through `SEL_SETUP`+`STEP_HOLD`+k·(`STEP_HOLD`+`STEP_GAP`).
  - `done` is high in cycle `SEL_SETUP`+N·(`STEP_HOLD`+`STEP_GAP`)+1.
  - `req_ready` is high again in the following cycle.
- A steps=0 request gives `done` in cycle 1. `req_ready` stays high throughout.
- From reset release:
  - `pll_reset` is high for exactly `RST_CYCLES` cycles.
  - `req_ready` rises no earlier than 3 cycles after `locked` rises (2-flop sync plus the state transition).
- Lock loss is detected 2 cycles after `locked` falls (synchronizer latency). Abort completes 1 cycle after detection.

## Test plan
- Reset, then `locked` rises 10 cycles after `pll_reset` falls -> `pll_reset` high for 16 cycles; `req_ready`=1 three cycles after `locked` rises; all `pos`=0.
- Request sel=2, dir=1, steps=3 (defaults) -> three `phasestep` pulses of 4 cycles high / 4 low; first rise at cycle 3; `done` at cycle 27; `phasesel`=2 throughout; `pos_o[47:32]`=3.
- Request sel=0, dir=0, steps=1 from `pos`=0 -> `pos_o[15:0]`=0xFFFF; then sel=0, dir=1, steps=255 -> 0x00FE; steps=0 request -> `done` at cycle 1 with no pulse.
- Drop `locked` during step 2 of 5 -> `phasestep` low 3 cycles after the drop; `err_lock`=1; `done` pulse; `pos` moved by exactly 2; `req_ready`=0 until relock.
- Hold `locked`=0 with `LOCK_TIMEOUT`=100 -> `err_timeout` set after 100 cycles in `WAIT_LOCK`; a new 16-cycle `pll_reset` pulse follows; `err_clr` clears the flag.
- Assert `reset` mid-`STEP_HI`, and separately `relock_req`+`req_valid` in the same `IDLE` cycle -> reset: `phasestep`=0 on the next edge and all outputs at reset values; relock: request not accepted, `pos` cleared, `pll_reset` sequence starts.

Source files
------------

// File: rtl/ecp5pll_phase_ctrl.sv
// Phase-step sequencer and PLL reset/lock supervisor for the ecp5pll wrapper.
// Converts "move output N by K fine steps" requests into phasesel/phasedir/phasestep waveforms.
module ecp5pll_phase_ctrl #(
  parameter int unsigned SEL_SETUP    = 2,
  parameter int unsigned STEP_HOLD    = 4,
  parameter int unsigned STEP_GAP     = 4,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        clk_i,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_sel,
  input  logic        req_dir,
  input  logic [7:0]  req_steps,
  input  logic        relock_req,
  input  logic        err_clr,
  input  logic        locked,
  output logic        pll_reset,
  output logic [1:0]  phasesel,
  output logic        phasedir,
  output logic        phasestep,
  output logic        phaseloadreg,
  output logic        done,
  output logic        busy,
  output logic        err_lock,
  output logic        err_timeout,
  output logic [63:0] pos_o
);

  typedef enum logic [2:0] {
    S_RST_PLL, S_WAIT_LOCK, S_IDLE, S_SETUP, S_STEP_HI, S_STEP_LO
  } state_t;

  // One shared 16-bit cycle counter; every timing parameter must fit in it.
  localparam logic [15:0] RST_LAST   = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TO_LAST    = 16'(LOCK_TIMEOUT - 1);
  localparam logic [15:0] SETUP_LAST = 16'(SEL_SETUP - 1);
  localparam logic [15:0] HOLD_LAST  = 16'(STEP_HOLD - 1);
  localparam logic [15:0] GAP_LAST   = 16'(STEP_GAP - 1);

  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  rem_q, rem_d;
  logic [1:0]  sel_q, sel_d;
  logic        dir_q, dir_d;
  logic        sync1_q, lock_s_q;
  logic        pll_reset_q, pll_reset_d;
  logic        phasestep_q, phasestep_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        ready_q, ready_d;
  logic        err_lock_q, err_lock_d;
  logic        err_timeout_q, err_timeout_d;
  logic        set_err_lock, set_err_timeout;
  logic        abort;
  logic        pos_step, pos_clr;

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q + 16'd1;
    rem_d           = rem_q;
    sel_d           = sel_q;
    dir_d           = dir_q;
    done_d          = 1'b0;
    set_err_lock    = 1'b0;
    set_err_timeout = 1'b0;
    abort           = 1'b0;
    pos_step        = 1'b0;
    pos_clr         = 1'b0;

    case (state_q)
      S_RST_PLL: begin
        if (cnt_q == RST_LAST) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          set_err_timeout = 1'b1;
          state_d         = S_RST_PLL;
          cnt_d           = '0;
        end
      end
      S_IDLE: begin
        cnt_d = '0;
        if (relock_req) begin
          pos_clr = 1'b1;
          state_d = S_RST_PLL;
        end else if (!lock_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (req_valid && ready_q) begin
          sel_d = req_sel;
          dir_d = req_dir;
          rem_d = req_steps;
          if (req_steps == 8'd0) done_d = 1'b1;
          else                   state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!lock_s_q) begin
          abort = 1'b1;
        end else if (cnt_q == SETUP_LAST) begin
          state_d = S_STEP_HI;
          cnt_d   = '0;
        end
      end
      S_STEP_HI: begin
        // The pulse is already on the pins this cycle, so count it even if we abort now.
        if (cnt_q == 16'd0) begin
          pos_step = 1'b1;
          rem_d    = rem_q - 8'd1;
        end
        if (!lock_s_q) begin
          abort = 1'b1;
        end else if (cnt_q == HOLD_LAST) begin
          state_d = S_STEP_LO;
          cnt_d   = '0;
        end
      end
      S_STEP_LO: begin
        if (!lock_s_q) begin
          abort = 1'b1;
        end else if (cnt_q == GAP_LAST) begin
          cnt_d = '0;
          if (rem_q != 8'd0) begin
            state_d = S_STEP_HI;
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        state_d = S_RST_PLL;
        cnt_d   = '0;
      end
    endcase

    if (abort) begin
      state_d      = S_WAIT_LOCK;
      cnt_d        = '0;
      done_d       = 1'b1;
      set_err_lock = 1'b1;
    end

    pll_reset_d   = (state_d == S_RST_PLL);
    phasestep_d   = (state_d == S_STEP_HI);
    busy_d        = (state_d != S_IDLE);
    // Ready returns one cycle after a completion done, so done and a new accept never overlap.
    ready_d       = sync1_q && (state_d == S_IDLE) && (state_q != S_STEP_LO);
    err_lock_d    = set_err_lock | (err_lock_q & ~err_clr);
    err_timeout_d = set_err_timeout | (err_timeout_q & ~err_clr);
  end

  always_ff @(posedge clk_i) begin
    if (reset) begin
      state_q       <= S_RST_PLL;
      cnt_q         <= '0;
      rem_q         <= '0;
      sel_q         <= '0;
      dir_q         <= 1'b0;
      sync1_q       <= 1'b0;
      lock_s_q      <= 1'b0;
      pll_reset_q   <= 1'b1;
      phasestep_q   <= 1'b0;
      done_q        <= 1'b0;
      busy_q        <= 1'b1;
      ready_q       <= 1'b0;
      err_lock_q    <= 1'b0;
      err_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      sel_q         <= sel_d;
      dir_q         <= dir_d;
      sync1_q       <= locked;
      lock_s_q      <= sync1_q;
      pll_reset_q   <= pll_reset_d;
      phasestep_q   <= phasestep_d;
      done_q        <= done_d;
      busy_q        <= busy_d;
      ready_q       <= ready_d;
      err_lock_q    <= err_lock_d;
      err_timeout_q <= err_timeout_d;
    end
  end

  genvar gi;
  for (gi = 0; gi < 4; gi++) begin : g_pos
    logic [15:0] pos_q;
    always_ff @(posedge clk_i) begin
      if (reset || pos_clr) begin
        pos_q <= '0;
      end else if (pos_step && (sel_q == 2'(gi))) begin
        pos_q <= dir_q ? (pos_q + 16'd1) : (pos_q - 16'd1);
      end
    end
    assign pos_o[16*gi +: 16] = pos_q;
  end

  assign req_ready    = ready_q;
  assign pll_reset    = pll_reset_q;
  assign phasesel     = sel_q;
  assign phasedir     = dir_q;
  assign phasestep    = phasestep_q;
  assign phaseloadreg = 1'b0;
  assign done         = done_q;
  assign busy         = busy_q;
  assign err_lock     = err_lock_q;
  assign err_timeout  = err_timeout_q;

endmodule

// File: tb/tb_ecp5pll_phase_ctrl.sv
// Directed + randomized bench for ecp5pll_phase_ctrl against a cycle-formula and position model.
module tb_ecp5pll_phase_ctrl;

  localparam int S  = 2;
  localparam int H  = 4;
  localparam int G  = 4;
  localparam int P  = H + G;
  localparam int RC = 16;
  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic [1:0]  req_sel;
  logic        req_dir;
  logic [7:0]  req_steps;
  logic        relock_req;
  logic        err_clr;
  logic        locked;
  logic        pll_reset;
  logic [1:0]  phasesel;
  logic        phasedir;
  logic        phasestep;
  logic        phaseloadreg;
  logic        done;
  logic        busy;
  logic        err_lock;
  logic        err_timeout;
  logic [63:0] pos_o;

  int          n_vec = 0;
  int          n_err = 0;
  int unsigned mpos [4];

  ecp5pll_phase_ctrl #(
    .SEL_SETUP(S), .STEP_HOLD(H), .STEP_GAP(G), .RST_CYCLES(RC), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk_i(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_sel(req_sel), .req_dir(req_dir), .req_steps(req_steps),
    .relock_req(relock_req), .err_clr(err_clr), .locked(locked),
    .pll_reset(pll_reset), .phasesel(phasesel), .phasedir(phasedir),
    .phasestep(phasestep), .phaseloadreg(phaseloadreg), .done(done), .busy(busy),
    .err_lock(err_lock), .err_timeout(err_timeout), .pos_o(pos_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pos_vec();
    return {16'(mpos[3]), 16'(mpos[2]), 16'(mpos[1]), 16'(mpos[0])};
  endfunction

  // Net position change: each issued step moves the selected output by +/-1 modulo 2^16.
  task automatic apply_model(input logic [1:0] sel, input logic dir, input int n);
    mpos[sel] = (mpos[sel] + (dir ? n : 65536 - n)) % 65536;
  endtask

  function automatic logic exp_step(input int c, input int n);
    if (c >= S + 1 && c <= S + n * P) return ((c - S - 1) % P) < H;
    return 1'b0;
  endfunction

  task automatic count_level(input logic lvl, output int n);
    n = 0;
    while (pll_reset === lvl && n < 2000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_ready(input string tag, input int exp);
    int n = 0;
    while (req_ready !== 1'b1 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp >= 0) chk(tag, 64'(n), 64'(exp));
    else          chk(tag, 64'(req_ready), 64'd1);
  endtask

  task automatic run_req(input logic [1:0] sel, input logic dir, input int n);
    int dn, last;
    logic [6:0] e, o;
    chk("ready_before_req", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_sel = sel; req_dir = dir; req_steps = 8'(n);
    @(negedge clk);
    req_valid = 1'b0;
    dn   = (n == 0) ? 1 : S + n * P + 1;
    last = dn + 1;
    for (int c = 1; c <= last; c++) begin
      e = {exp_step(c, n), (c == dn), (n == 0) || (c > dn), (n != 0) && (c < dn), sel, dir};
      o = {phasestep, done, req_ready, busy, phasesel, phasedir};
      chk($sformatf("req_s%0d_d%0d_n%0d_c%0d", sel, dir, n, c), 64'(o), 64'(e));
      if (c < last) @(negedge clk);
    end
    apply_model(sel, dir, n);
    chk("pos_after_req", pos_o, pos_vec());
    $display("req sel=%0d dir=%0d steps=%0d pos=%016h", sel, dir, n, pos_o);
  endtask

  // locked drops mid-cycle d; lock_s sees it in cycle d+2 and the abort shows in cycle d+3.
  task automatic run_drop(input logic [1:0] sel, input logic dir, input int n, input int d);
    int issued = 0;
    logic [6:0] e, o;
    chk("ready_before_drop", 64'(req_ready), 64'd1);
    req_valid = 1'b1; err_clr = 1'b1; req_sel = sel; req_dir = dir; req_steps = 8'(n);
    @(negedge clk);
    req_valid = 1'b0; err_clr = 1'b0;
    for (int c = 1; c <= d + 3; c++) begin
      if (c <= d + 2) e = {exp_step(c, n), 1'b0, 1'b0, 1'b1, 1'b0, sel};
      else            e = {1'b0, 1'b1, 1'b0, 1'b1, 1'b1, sel};
      o = {phasestep, done, req_ready, busy, err_lock, phasesel};
      chk($sformatf("drop_n%0d_d%0d_c%0d", n, d, c), 64'(o), 64'(e));
      if (c == d) locked = 1'b0;
      if (c < d + 3) @(negedge clk);
    end
    for (int k = 0; k < n; k++) if (S + 1 + k * P <= d + 2) issued++;
    apply_model(sel, dir, issued);
    chk("pos_after_drop", pos_o, pos_vec());
    $display("drop sel=%0d dir=%0d steps=%0d at=%0d issued=%0d pos=%016h", sel, dir, n, d, issued, pos_o);
  endtask

  initial begin
    int n, rn, dd;
    logic [1:0]  rs;
    logic        rd;
    logic [10:0] rst_vec;
    logic [6:0]  rl_exp;

    rst_vec = 11'b10000000100;
    reset = 1'b1; locked = 1'b0; req_valid = 1'b0; req_sel = '0; req_dir = 1'b0;
    req_steps = '0; relock_req = 1'b0; err_clr = 1'b0;
    for (int i = 0; i < 4; i++) mpos[i] = 0;

    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({pll_reset, phasestep, phasesel, phasedir, phaseloadreg, done,
                              req_ready, busy, err_lock, err_timeout}), 64'(rst_vec));
    chk("reset_pos", pos_o, pos_vec());
    reset = 1'b0;
    count_level(1'b1, n);
    chk("pll_reset_len", 64'(n), 64'(RC));
    repeat (10) @(negedge clk);
    locked = 1'b1;
    wait_ready("lock_to_ready", 3);
    chk("pos_zero", pos_o, pos_vec());

    run_req(2'd2, 1'b1, 3);
    run_req(2'd0, 1'b0, 1);
    run_req(2'd0, 1'b1, 255);
    run_req(2'd1, 1'b0, 0);
    for (int i = 0; i < 8; i++) begin
      rs = 2'($urandom_range(3, 0));
      rd = 1'($urandom_range(1, 0));
      rn = int'($urandom_range(6, 0));
      run_req(rs, rd, rn);
    end

    // Lock lost during the second of five steps, then held off long enough to time out.
    run_drop(2'd3, 1'b1, 5, 11);
    chk("ready_low_while_unlocked", 64'({req_ready, busy}), 64'(2'b01));
    count_level(1'b0, n);
    chk("timeout_len", 64'(n), 64'(TO));
    chk("timeout_flags", 64'({err_timeout, err_lock}), 64'(2'b11));
    count_level(1'b1, n);
    chk("retry_reset_len", 64'(n), 64'(RC));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 64'({err_lock, err_timeout}), 64'd0);
    locked = 1'b1;
    wait_ready("relock_after_timeout", 3);

    for (int i = 0; i < 2; i++) begin
      rs = 2'($urandom_range(3, 0));
      rd = 1'($urandom_range(1, 0));
      rn = int'($urandom_range(8, 1));
      dd = int'($urandom_range(S + rn * P - 2, 1));
      run_drop(rs, rd, rn, dd);
      locked = 1'b1;
      wait_ready("relock_after_drop", 3);
    end

    // Reset arriving in the middle of a STEP_HI pulse.
    req_valid = 1'b1; req_sel = 2'd1; req_dir = 1'b1; req_steps = 8'd4;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_step_high", 64'(phasestep), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) mpos[i] = 0;
    chk("midstep_reset_outputs", 64'({pll_reset, phasestep, phasesel, phasedir, phaseloadreg, done,
                                      req_ready, busy, err_lock, err_timeout}), 64'(rst_vec));
    chk("midstep_reset_pos", pos_o, pos_vec());
    $display("reset mid-step pos=%016h", pos_o);
    reset = 1'b0;
    count_level(1'b1, n);
    chk("pll_reset_len_2", 64'(n), 64'(RC));
    wait_ready("ready_after_reset", -1);

    // relock_req wins over a simultaneous request.
    run_req(2'd2, 1'b0, 2);
    req_valid = 1'b1; relock_req = 1'b1; req_sel = 2'd1; req_dir = 1'b1; req_steps = 8'd5;
    @(negedge clk);
    req_valid = 1'b0; relock_req = 1'b0;
    for (int i = 0; i < 4; i++) mpos[i] = 0;
    rl_exp = {1'b1, 1'b1, 1'b0, 1'b0, 2'd2, 1'b0};
    chk("relock_ctrl", 64'({pll_reset, busy, req_ready, done, phasesel, phasedir}), 64'(rl_exp));
    chk("relock_pos", pos_o, pos_vec());
    $display("relock pos=%016h", pos_o);
    count_level(1'b1, n);
    chk("relock_reset_len", 64'(n), 64'(RC));
    wait_ready("ready_after_relock", -1);
    run_req(2'd1, 1'b1, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
